// File: rtl/keypad_scan_pkg.sv
// rtl/keypad_scan_pkg.sv - shared state encodings, row constants and key codes for keypad_scan
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    KS_SCAN  = 2'd0,
    KS_DEB   = 2'd1,
    KS_PRESS = 2'd2,
    KS_REL   = 2'd3
  } ks_state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Front-panel legend, code = row*4 + col
  localparam logic [3:0] KEY_1     = 4'd0;
  localparam logic [3:0] KEY_2     = 4'd1;
  localparam logic [3:0] KEY_3     = 4'd2;
  localparam logic [3:0] KEY_START = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_STOP  = 4'd7;
  localparam logic [3:0] KEY_7     = 4'd8;
  localparam logic [3:0] KEY_8     = 4'd9;
  localparam logic [3:0] KEY_9     = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_MIN   = 4'd12;
  localparam logic [3:0] KEY_0     = 4'd13;
  localparam logic [3:0] KEY_SEC   = 4'd14;
  localparam logic [3:0] KEY_DEG   = 4'd15;

  function automatic logic single_low(input logic [3:0] p);
    return ($countones(~p) == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - row synchronizer plus "stable for N samples" counter and strobe
module key_debounce
  import keypad_scan_pkg::*;
#(
  parameter int N = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic       clr,
  input  logic [3:0] target,
  output logic [3:0] rs,
  output logic       match,
  output logic       done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [3:0]       s1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= ROWS_IDLE;
      rs <= ROWS_IDLE;
    end else begin
      s1 <= row_in;
      rs <= s1;
    end
  end

  assign match = (rs == target);
  // Strobe fires on the sample that brings the run length up to N
  assign done  = match && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !match) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounced one-cycle key events
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CYCLES = 1000
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_PERIOD = 10000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);

  ks_state_t        state;
  logic [1:0]       col;
  logic [CNT_W-1:0] dwell;
  logic [3:0]       pat;
  logic [3:0]       rs;
  logic [3:0]       target;
  logic             match;
  logic             done;
  logic             clr;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_first;
`endif

  // One counter serves both the press check (against P) and the release check (against idle)
  assign target = (state == KS_REL) ? ROWS_IDLE : pat;
  assign clr    = (state == KS_SCAN) || (state == KS_PRESS) || ((state == KS_DEB) && done);

  key_debounce #(.N(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .row_in (row_in),
    .clr    (clr),
    .target (target),
    .rs     (rs),
    .match  (match),
    .done   (done)
  );

  assign col_out = ~(4'b0001 << col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= KS_SCAN;
      col       <= 2'd0;
      dwell     <= '0;
      pat       <= ROWS_IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        KS_SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (rs == ROWS_IDLE) begin
              col <= col + 2'd1;
            end else begin
              pat   <= rs;
              state <= KS_DEB;
            end
          end else if (dwell != CNT_MAX) begin
            dwell <= dwell + 1'b1;
          end
        end
        KS_DEB: begin
          if (!match) begin
            state <= KS_SCAN;
            col   <= col + 2'd1;
          end else if (done) begin
            if (single_low(pat)) begin
              key_code  <= {low_index(pat), col};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= KS_PRESS;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b1;
`endif
            end else begin
              state <= KS_REL;
            end
          end
        end
        KS_PRESS: begin
          if (rs == ROWS_IDLE) begin
            key_held <= 1'b0;
            state    <= KS_REL;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
            key_valid <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else if (rep_cnt != CNT_MAX) begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        KS_REL: begin
          if (done) begin
            state <= KS_SCAN;
            col   <= col + 2'd1;
          end
        end
        default: state <= KS_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - randomized scoreboard bench for keypad_scan against a physical keypad model
module tb_keypad_scan;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 8;
  localparam int PRESS_LAT  = (SCAN_DIV - 1) + (DEB_CYCLES + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int REPEAT_DELAY  = 40;
  localparam int REPEAT_PERIOD = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q[$];

  keypad_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_CYCLES (DEB_CYCLES)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // A closed switch pulls its row low only while its column is driven
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic logic [3:0] exp_col(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (i % 4));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every key event
  logic [3:0] prev_col = 4'b1110;
  int         col_since = 0;
  logic       prev_valid = 1'b0;
  logic       prev_held = 1'b0;
  int         last_ev = 0;
  int         rep_n = 0;
  int         rep_total = 0;
  int         exp_code;

  always @(negedge clk) begin
    if (col_out !== prev_col) begin
      col_since = cyc;
      prev_col  = col_out;
    end
    if (key_valid === 1'b1) begin
      check("valid_not_back_to_back", prev_valid, 0);
`ifdef KEYPAD_REPEAT_EN
      if (prev_held === 1'b1) begin
        check("repeat_gap", cyc - last_ev, (rep_n == 0) ? REPEAT_DELAY : REPEAT_PERIOD);
        rep_n++;
        rep_total++;
      end else
`endif
      begin
        rep_n = 0;
        check("event_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_code = exp_q.pop_front();
          check("key_code", key_code, exp_code);
          check("press_latency", cyc - col_since, PRESS_LAT);
          check("held_with_valid", key_held, 1);
        end
      end
      last_ev = cyc;
    end
    prev_valid = key_valid;
    prev_held  = key_held;
  end

  task automatic press(input int k, input int hold, input bit bounce);
    int c;
    int q;
    int t;
    c = k % 4;
    @(posedge clk); #1;
    exp_q.push_back(k);
    if (bounce)
      for (int i = 0; i < 5; i++) begin
        pressed[k] = ~pressed[k];
        @(posedge clk); #1;
      end
    pressed[k] = 1'b1;
    t = 0;
    while (key_held !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    check("held_rises", key_held, 1);
    repeat (hold) @(posedge clk);
    #1;
    check("held_during", key_held, 1);
    pressed[k] = 1'b0;
    q = cyc;
    t = 0;
    while (key_held !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    check("held_drop_delay", cyc - q, 3);
    t = 0;
    while (col_out === exp_col(c) && t < 50) begin @(negedge clk); t++; end
    check("resume_delay", cyc - q, 11);
    check("resume_col", col_out, exp_col(c + 1));
  endtask

  task automatic ghost(input int c, input int r1, input int r2);
    int q;
    int t;
    @(posedge clk); #1;
    pressed[r1*4+c] = 1'b1;
    pressed[r2*4+c] = 1'b1;
    repeat (60) @(negedge clk);
    check("ghost_frozen_col", col_out, exp_col(c));
    check("ghost_no_held", key_held, 0);
    @(posedge clk); #1;
    pressed = '0;
    q = cyc;
    t = 0;
    while (col_out === exp_col(c) && t < 50) begin @(negedge clk); t++; end
    check("ghost_resume_delay", cyc - q, 10);
    check("ghost_resume_col", col_out, exp_col(c + 1));
  endtask

  task automatic reset_mid(input int k);
    int c;
    int run;
    int t;
    c = k % 4;
    run = 0;
    t = 0;
    @(posedge clk); #1;
    pressed[k] = 1'b1;
    while (run < 6 && t < 200) begin
      @(negedge clk);
      t++;
      if (col_out === exp_col(c)) run++;
      else run = 0;
    end
    check("reached_debounce", run, 6);
    #1 rst = 1'b1;
    #1;
    check("rst_col", col_out, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    repeat (3) @(negedge clk);
    pressed = '0;
    check("rst_col_hold", col_out, 4'b1110);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int c;
    int r1;
    int r2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_col", col_out, 4'b1110);
    check("reset_code", key_code, 0);
    check("reset_valid", key_valid, 0);
    check("reset_held", key_held, 0);
    rst = 1'b0;

    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      check("idle_col", col_out, exp_col((n + 1) / SCAN_DIV));
    end

    press(9, 20, 1'b0);
    press(6, 15, 1'b1);
    ghost(0, 1, 3);
    reset_mid(6);

`ifdef KEYPAD_REPEAT_EN
    k = rep_total;
    press(5, 100, 1'b0);
    check("repeat_count", rep_total - k, 4);
`endif

    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 15);
      press(k, $urandom_range(5, 30), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      c  = $urandom_range(0, 3);
      r1 = $urandom_range(0, 3);
      r2 = (r1 + 1 + $urandom_range(0, 2)) % 4;
      ghost(c, r1, r2);
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
